tdoa_collector: RTL and testbench
=================================

Name: tdoa_collector

Overview:
Consumes the valid/detect_time/ack outputs of N per-microphone Threshold detectors.
- Gathers one detection per channel within a bounded window.
- Picks the earliest channel as reference and computes each channel's arrival-time delta relative to it.
- Presents one result record to the host/UART side with a valid/ack handshake, then acks all Threshold stages so they re-arm.

Parameters:
N_CH, 3, number of Threshold channels (2..8)
TW, 32, detect_time width
WINDOW, 1000, collection timeout in clk cycles, counted from first capture (timeout feature only)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ch_valid  in  N_CH  per-channel valid from Threshold
ch_time  in  N_CH*TW  per-channel detect_time, channel i at bits [i*TW +: TW]
ch_ack  out  N_CH  per-channel ack to Threshold, 1-cycle pulse
out_valid  out  1  result record available
out_ack  in  1  consumer accepts record
out_ref  out  3  index of earliest channel
out_mask  out  N_CH  channels that contributed a time
out_delta  out  N_CH*TW  unsigned delta of channel i vs reference; 0 for the reference and for masked-out channels

Behaviour:
- Reset: state=IDLE; all outputs 0; captured times, mask and window counter cleared. Reset mid-operation discards any partial record; no ch_ack is issued.
- IDLE: any ch_valid bit high -> latch ch_time for every asserting channel, set its mask bit, start window counter, go to COLLECT.
- COLLECT:
  - A channel is captured once only; later re-assertion while its mask bit is set is ignored.
  - Simultaneous valids are all captured in the same cycle.
  - mask all ones -> FIND.
- FIND: N_CH cycles, one channel per cycle.
  - Running minimum over masked channels only.
  - Comparison is wrap-safe: a is earlier than b iff signed(a-b) < 0 at TW bits.
  - Equal times: lower index wins.
- DIFF: N_CH cycles.
  - delta_i = time_i - time_ref, modulo 2^TW, for masked channels; 0 otherwise.
- PRESENT: out_valid=1; out_ref, out_mask and out_delta stable until out_ack is sampled high, then -> RELEASE.
- RELEASE: single cycle; ch_ack[i]=1 for every channel with ch_valid[i]=1 in that cycle (captured or stale); out_valid=0; clear mask -> IDLE.
- Latency: out_valid rises exactly 2*N_CH+1 cycles after the capture cycle that completes the mask.
- ch_valid seen during FIND/DIFF/PRESENT is not captured and is left pending for the RELEASE ack.
- out_ack is ignored unless out_valid=1.

Optional Feature:
TDOA_COLLECTOR_TIMEOUT_EN
- Defined:
  - In COLLECT, the window counter increments every cycle.
  - When counter == WINDOW-1 and the mask is incomplete -> FIND with the partial mask.
  - A capture in that same cycle is still included.
- Not defined:
  - No counter exists; COLLECT waits indefinitely for all channels.
  - WINDOW is unused.

Decomposition:
- Package tdoa_pkg: state encoding (IDLE, COLLECT, FIND, DIFF, PRESENT, RELEASE), TW default, wrap-safe "earlier" compare function.
- One natural sub-module, tdoa_min_seq: sequential earliest-index search used by FIND.
- Delta arithmetic stays inline.

Test Plan:
- N_CH=3; ch0=100, ch2=120, ch1=140 on separate cycles -> out_ref=0, out_mask=111, deltas 0/40/20. out_valid rises 7 cycles after the ch1 capture.
- Wrap-around: ch0=0xFFFFFFF0, ch1=0x10, ch2=0x0 -> out_ref=0, deltas 0/0x20/0x10.
- Equal and simultaneous: ch0=50 and ch1=50 in the same cycle, then ch2=60 -> out_ref=0, deltas 0/0/10. Re-pulsed ch0=70 during COLLECT is ignored.
- Handshake: hold out_ack low 20 cycles -> record stable throughout. out_ack pulse -> next cycle ch_ack=111 for one cycle, out_valid=0, state IDLE.
- Timeout (macro on, WINDOW=1000): only ch0=10 and ch2=30 arrive -> FIND after 1000 cycles; out_mask=101, out_ref=0, delta1=0, delta2=20.
- Reset mid-COLLECT after one capture -> all outputs 0 and no ch_ack. A fresh 3-channel event then completes normally.

Source files
------------

// File: rtl/tdoa_pkg.sv
// Shared types and helpers for the TDOA collector: FSM encoding, default
// time width and the wrap-safe arrival-order compare.
package tdoa_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    FIND    = 3'd2,
    DIFF    = 3'd3,
    PRESENT = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam int TW_DEF = 32;
  localparam int IW     = 3;

  // a is earlier than b iff (a-b) is negative at tw bits; the shift moves
  // bit tw-1 of the difference into the top bit so any tw up to 64 works.
  function automatic logic earlier(input logic [63:0] a, input logic [63:0] b,
                                   input int tw);
    logic [63:0] d;
    d = (a - b) << (64 - tw);
    return d[63];
  endfunction

endpackage

// File: rtl/tdoa_collector_if.sv
// Threshold-side and host-side signals of the TDOA collector.
// slave = collector, master = Threshold stages plus record consumer.
interface tdoa_collector_if #(
  parameter int N_CH = 3,
  parameter int TW   = 32
);
  logic [N_CH-1:0]         ch_valid;
  logic [N_CH-1:0][TW-1:0] ch_time;
  logic [N_CH-1:0]         ch_ack;
  logic                    out_valid;
  logic                    out_ack;
  logic [2:0]              out_ref;
  logic [N_CH-1:0]         out_mask;
  logic [N_CH-1:0][TW-1:0] out_delta;

  modport slave (
    input  ch_valid, ch_time, out_ack,
    output ch_ack, out_valid, out_ref, out_mask, out_delta
  );

  modport master (
    output ch_valid, ch_time, out_ack,
    input  ch_ack, out_valid, out_ref, out_mask, out_delta
  );
endinterface

// File: rtl/tdoa_min_seq.sv
// Sequential earliest-channel search: one channel per step, masked channels
// only, strict compare so the lower index wins a tie.
import tdoa_pkg::*;

module tdoa_min_seq #(
  parameter int N_CH = 3,
  parameter int TW   = TW_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    step_i,
  input  logic [IW-1:0]           idx_i,
  input  logic [N_CH-1:0][TW-1:0] times_i,
  input  logic [N_CH-1:0]         mask_i,
  output logic [IW-1:0]           ref_o,
  output logic [TW-1:0]           ref_time_o
);

  logic          have_q;
  logic [IW-1:0] best_idx_q;
  logic [TW-1:0] best_time_q;
  logic [TW-1:0] cur_time;
  logic          cur_mask;
  logic          take;

  always_comb begin
    cur_time = '0;
    cur_mask = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_i == IW'(i)) begin
        cur_time = times_i[i];
        cur_mask = mask_i[i];
      end
    end
  end

  assign take = step_i && cur_mask &&
                (!have_q || earlier(64'(cur_time), 64'(best_time_q), TW));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      have_q      <= 1'b0;
      best_idx_q  <= '0;
      best_time_q <= '0;
    end else if (take) begin
      have_q      <= 1'b1;
      best_idx_q  <= idx_i;
      best_time_q <= cur_time;
    end
  end

  assign ref_o      = best_idx_q;
  assign ref_time_o = best_time_q;

endmodule

// File: rtl/tdoa_collector.sv
// Collects one detect_time per channel, picks the earliest as reference and
// presents per-channel deltas. Optional window timeout: TDOA_COLLECTOR_TIMEOUT_EN.
import tdoa_pkg::*;

module tdoa_collector #(
  parameter int N_CH   = 3,
  parameter int TW     = TW_DEF,
  parameter int WINDOW = 1000
) (
  input  logic            clk,
  input  logic            rst,
  tdoa_collector_if.slave bus
);

  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

  state_t                  state_q;
  logic [N_CH-1:0]         mask_q, mask_d, cap;
  logic [N_CH-1:0][TW-1:0] time_q, delta_q;
  logic [IW-1:0]           idx_q, ref_idx;
  logic [TW-1:0]           ref_time;
  logic                    out_valid_q;
  logic [2:0]              out_ref_q;
  logic [N_CH-1:0]         out_mask_q;
  logic                    win_hit;

`ifdef TDOA_COLLECTOR_TIMEOUT_EN
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  logic [CW-1:0] win_q;
  assign win_hit = (win_q == CW'(WINDOW - 1));
`else
  assign win_hit = 1'b0;
`endif

  // Only unmasked channels capture, and only while gathering.
  assign cap    = (state_q == IDLE || state_q == COLLECT) ? (bus.ch_valid & ~mask_q) : '0;
  assign mask_d = mask_q | cap;

  tdoa_min_seq #(.N_CH(N_CH), .TW(TW)) u_min (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (state_q == COLLECT),
    .step_i     (state_q == FIND),
    .idx_i      (idx_q),
    .times_i    (time_q),
    .mask_i     (mask_q),
    .ref_o      (ref_idx),
    .ref_time_o (ref_time)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      time_q      <= '0;
      delta_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_ref_q   <= '0;
      out_mask_q  <= '0;
`ifdef TDOA_COLLECTOR_TIMEOUT_EN
      win_q       <= '0;
`endif
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (cap[i]) time_q[i] <= bus.ch_time[i];
      mask_q <= mask_d;
      case (state_q)
        IDLE: begin
          if (|cap) state_q <= COLLECT;
`ifdef TDOA_COLLECTOR_TIMEOUT_EN
          win_q <= '0;
`endif
        end
        // Full-mask exit looks at the registered mask, giving the fixed
        // 2*N_CH+1 latency from the completing capture.
        COLLECT: begin
`ifdef TDOA_COLLECTOR_TIMEOUT_EN
          win_q <= win_q + 1'b1;
`endif
          if (&mask_q || win_hit) begin
            state_q <= FIND;
            idx_q   <= '0;
          end
        end
        FIND: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q   <= '0;
            state_q <= DIFF;
          end
        end
        DIFF: begin
          for (int i = 0; i < N_CH; i++)
            if (idx_q == IW'(i))
              delta_q[i] <= mask_q[i] ? (time_q[i] - ref_time) : '0;
          idx_q <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            idx_q       <= '0;
            state_q     <= PRESENT;
            out_valid_q <= 1'b1;
            out_ref_q   <= ref_idx;
            out_mask_q  <= mask_q;
          end
        end
        PRESENT: begin
          if (bus.out_ack) begin
            out_valid_q <= 1'b0;
            state_q     <= RELEASE;
          end
        end
        RELEASE: begin
          mask_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ack whatever Threshold stages are asserting now, stale ones included.
  assign bus.ch_ack    = (state_q == RELEASE) ? bus.ch_valid : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ref   = out_ref_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.out_delta = delta_q;

endmodule

// File: tb/tb_tdoa_collector.sv
// Directed bench for tdoa_collector (N_CH=3, TW=32, WINDOW=1000); Threshold
// stages are modelled as valids held until their ch_ack pulse.
module tb_tdoa_collector;

  localparam int N  = 3;
  localparam int TW = 32;

  logic clk, rst;
  int   errs, nchk;
  logic [N-1:0] snap;
  int   n;
  logic stable;

  tdoa_collector_if #(.N_CH(N), .TW(TW)) bus ();

  tdoa_collector #(.N_CH(N), .TW(TW), .WINDOW(1000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; acked channels drop valid just after the edge.
  task automatic cyc();
    @(negedge clk);
    snap = bus.ch_ack;
    @(posedge clk);
    #1;
    bus.ch_valid = bus.ch_valid & ~snap;
  endtask

  task automatic fire(input int ch, input logic [TW-1:0] t);
    bus.ch_valid[ch] = 1'b1;
    bus.ch_time[ch]  = t;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 2000) begin
      cyc();
      cnt++;
    end
    chk("out_valid_seen", 64'(bus.out_valid), 64'd1);
  endtask

  task automatic chk_rec(input string tag, input logic [2:0] r, input logic [N-1:0] m,
                         input logic [TW-1:0] d0, input logic [TW-1:0] d1,
                         input logic [TW-1:0] d2);
    chk({tag, "_ref"},  64'(bus.out_ref),      64'(r));
    chk({tag, "_mask"}, 64'(bus.out_mask),     64'(m));
    chk({tag, "_d0"},   64'(bus.out_delta[0]), 64'(d0));
    chk({tag, "_d1"},   64'(bus.out_delta[1]), 64'(d1));
    chk({tag, "_d2"},   64'(bus.out_delta[2]), 64'(d2));
  endtask

  task automatic finish_rec(input string tag, input logic [N-1:0] exp_ack);
    bus.out_ack = 1'b1;
    cyc();
    bus.out_ack = 1'b0;
    chk({tag, "_rel_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_rel_ack"},   64'(bus.ch_ack),    64'(exp_ack));
    cyc();
    chk({tag, "_ack_off"},   64'(bus.ch_ack),    64'd0);
  endtask

  initial begin
    errs = 0;
    nchk = 0;
    rst = 1'b1;
    bus.ch_valid = '0;
    bus.ch_time  = '0;
    bus.out_ack  = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_ack",   64'(bus.ch_ack),    64'd0);
    chk("rst_mask",  64'(bus.out_mask),  64'd0);
    rst = 1'b0;
    cyc();

    // Separate arrivals, latency from the completing capture.
    fire(0, 100); cyc();
    fire(2, 120); cyc();
    fire(1, 140); cyc();
    wait_valid(n);
    chk("latency", 64'(n), 64'd7);
    chk_rec("basic", 3'd0, 3'b111, 0, 40, 20);

    // Held record stays put while out_ack is low.
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (!bus.out_valid || bus.out_delta[1] != 40 || bus.out_delta[2] != 20 ||
          bus.out_ref != 0 || bus.out_mask != 3'b111 || bus.ch_ack != 0)
        stable = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'd1);
    finish_rec("basic", 3'b111);
    cyc();
    chk("idle_no_cap", 64'(bus.out_valid), 64'd0);

    // Wrap-around of the time counter.
    fire(0, 32'hFFFF_FFF0); cyc();
    fire(1, 32'h10);        cyc();
    fire(2, 32'h0);         cyc();
    wait_valid(n);
    chk_rec("wrap", 3'd0, 3'b111, 0, 32'h20, 32'h10);
    finish_rec("wrap", 3'b111);

    // Simultaneous equal times; ch0 re-pulse with 70 ignored.
    fire(0, 50); fire(1, 50); cyc();
    bus.ch_valid[0] = 1'b0; cyc();
    fire(0, 70); cyc();
    fire(2, 60); cyc();
    wait_valid(n);
    chk("tie_latency", 64'(n), 64'd7);
    chk_rec("tie", 3'd0, 3'b111, 0, 0, 10);
    finish_rec("tie", 3'b111);

    // Only ch0 and ch2 arrive.
    fire(0, 10); cyc();
    fire(2, 30); cyc();
`ifdef TDOA_COLLECTOR_TIMEOUT_EN
    wait_valid(n);
    chk("timeout_latency", 64'(n), 64'd1005);
    chk_rec("timeout", 3'd0, 3'b101, 0, 0, 20);
    finish_rec("timeout", 3'b101);
`else
    for (int i = 0; i < 1100; i++) cyc();
    chk("no_timeout_wait", 64'(bus.out_valid), 64'd0);
    fire(1, 20); cyc();
    wait_valid(n);
    chk("late_latency", 64'(n), 64'd7);
    chk_rec("late", 3'd0, 3'b111, 0, 10, 20);
    finish_rec("late", 3'b111);
`endif

    // Reset mid-COLLECT discards the partial record.
    fire(0, 5); cyc();
    rst = 1'b1;
    bus.ch_valid = '0;
    cyc();
    chk("mid_rst_ack",   64'(bus.ch_ack),    64'd0);
    cyc();
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_mask",  64'(bus.out_mask),  64'd0);
    chk("mid_rst_ref",   64'(bus.out_ref),   64'd0);
    chk("mid_rst_delta", 64'(bus.out_delta), 64'd0);
    rst = 1'b0;
    cyc();
    fire(0, 200); cyc();
    fire(1, 190); cyc();
    fire(2, 210); cyc();
    wait_valid(n);
    chk("fresh_latency", 64'(n), 64'd7);
    chk_rec("fresh", 3'd1, 3'b111, 10, 0, 20);
    finish_rec("fresh", 3'b111);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
